instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Byte-stream loader that programs the byte-celled, big-endian instruction memory before the pipeline runs. It accepts a framed byte stream over a valid/ready handshake: a 16-bit word count, then the payload, then an XOR checksum. It packs every 4 bytes into one word and issues a single-cycle word write. It holds the CPU while a load is active and reports done or error.

Parameters:
WORD_LEN, 32, instruction word width in bits.
MEM_CELL_SIZE, 8, memory cell width in bits (one byte).
INSTR_MEM_SIZE, 1024, instruction memory size in bytes.
ADDR_W, 10, byte address width, equal to clog2(INSTR_MEM_SIZE).
MAX_WORDS, 256, INSTR_MEM_SIZE/4, the largest legal word count.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
in_data  in  8  stream byte.
in_valid  in  1  in_data is valid.
in_ready  out  1  loader accepts a byte; a byte transfers when in_valid && in_ready at the edge.
wr_en  out  1  one-cycle word write strobe.
wr_addr  out  ADDR_W  word-aligned byte address of the write; wr_addr[1:0] is always 0.
wr_data  out  32  packed word; the first received byte goes in [31:24] and lands at wr_addr.
cpu_hold  out  1  stalls/holds the CPU; high whenever busy.
busy  out  1  a load is in progress.
done  out  1  last load completed with a good checksum; level signal.
err  out  1  last load failed (overflow or checksum mismatch); level signal.

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready, wr_en, busy, cpu_hold, done and err are all 0.
  - wr_addr and wr_data are 0.
  - Byte counter, word counter and checksum are cleared.
  - A reset mid-load aborts the load. No further writes occur. Words already written stay in memory.
- States: IDLE, CNT_HI, CNT_LO, DATA, CHK, DONE, ERR.
  - in_ready = 1 only in CNT_HI, CNT_LO, DATA and CHK.
  - busy = cpu_hold = 1 in the same states.
- IDLE, DONE or ERR with start=1 -> CNT_HI.
  - done and err clear, wr_addr clears to 0, checksum clears to 0.
  - in_ready rises in the next cycle. A byte presented in the start cycle is not accepted.
- Start in any other state is ignored.
- CNT_HI: the accepted byte goes to N[15:8], then -> CNT_LO.
- CNT_LO: the accepted byte goes to N[7:0].
  - If N > MAX_WORDS -> ERR; no payload is consumed.
  - Else if N == 0 -> CHK.
  - Else -> DATA.
- DATA:
  - Each accepted byte shifts into the packer and is XORed into the checksum. Count bytes are not checksummed.
  - On the 4th byte of a word: wr_data gets the packed word and wr_en = 1 for exactly the following cycle at the current wr_addr. wr_addr then advances by 4.
  - in_ready stays high throughout. A new byte may be accepted in the same cycle wr_en is high.
  - After word N is written -> CHK.
- CHK: the accepted byte is compared to the running checksum.
  - Equal -> DONE with done=1.
  - Unequal -> ERR with err=1.
- DONE and ERR hold until start or rst.
- in_valid=0 stalls the FSM indefinitely with no timeout.
- Bytes offered while in_ready=0 are ignored and not consumed.
- wr_addr never wraps: the overflow check bounds the last address to INSTR_MEM_SIZE-4.
- wr_data holds its last value between strobes.

Decomposition:
- Shared package:
  - Constants WORD_LEN, MEM_CELL_SIZE, INSTR_MEM_SIZE, ADDR_W and MAX_WORDS, reused with the memory.
  - The loader state enum.
  - Count width 16.
- One natural sub-module, loader_word_packer:
  - Contains the 2-bit byte index, the 32-bit shift register and the word_ready pulse.
  - Has its own clear input.
  - The FSM, counters and checksum stay in the top module.

Test Plan:
1. start, then stream 00 02, 80 20 00 0A, 04 40 08 00, E6 with in_valid held high -> wr_en pulses with (addr 0, 0x8020000A) then (addr 4, 0x04400800); done=1, err=0; cpu_hold low after CHK.
2. Same stream with checksum 0xE7 -> both words written, err=1, done=0, state ERR; a new start clears err.
3. Count 01 01 (257) -> ERR immediately after the second count byte; no wr_en; in_ready=0 afterwards.
4. Count 00 00, checksum 00 -> DONE, zero writes. Count 01 00 (256) with 1024 bytes -> last write at addr 1020 (0x3FC), no wrap.
5. Case 1 with in_valid toggling randomly (about 50% duty) -> identical writes and final done; no byte is lost or duplicated.
6. rst asserted after the 6th payload byte, then in_valid stays high -> outputs return to reset values; only the addr-0 word was written; a fresh start reloads correctly.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The memory geometry constants are shared with the instruction memory itself.
package instr_mem_loader_pkg;

    localparam int WORD_LEN       = 32;
    localparam int MEM_CELL_SIZE  = 8;
    localparam int INSTR_MEM_SIZE = 1024;
    localparam int ADDR_W         = $clog2(INSTR_MEM_SIZE);
    localparam int MAX_WORDS      = INSTR_MEM_SIZE / 4;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } ld_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and word-write output bus of the loader.
// The slave modport is the loader; the master modport is the stream source / memory side.
interface instr_mem_loader_if;
    import instr_mem_loader_pkg::*;

    logic [MEM_CELL_SIZE-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [WORD_LEN-1:0]      wr_data;

    modport slave  (input  in_data, in_valid,
                    output in_ready, wr_en, wr_addr, wr_data);
    modport master (output in_data, in_valid,
                    input  in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/instr_mem_loader_word_packer.sv
// Packs bytes big-endian into words; the first byte lands in [31:24].
// word_o is captured on the 4th byte and held, word_ready_o pulses the cycle after.
module loader_word_packer
    import instr_mem_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     byte_vld_i,
    input  logic [MEM_CELL_SIZE-1:0] byte_i,
    output logic                     last_o,
    output logic                     word_ready_o,
    output logic [WORD_LEN-1:0]      word_o
);

    logic [1:0]          idx_q;
    logic [WORD_LEN-1:0] shreg_q;
    logic [WORD_LEN-1:0] word_q;
    logic                rdy_q;
    logic [WORD_LEN-1:0] shreg_d;

    assign shreg_d      = {shreg_q[WORD_LEN-MEM_CELL_SIZE-1:0], byte_i};
    assign last_o       = (idx_q == 2'd3);
    assign word_ready_o = rdy_q;
    assign word_o       = word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            shreg_q <= '0;
            word_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (clr_i) begin
                idx_q   <= '0;
                shreg_q <= '0;
            end else if (byte_vld_i) begin
                shreg_q <= shreg_d;
                idx_q   <= idx_q + 2'd1;
                if (last_o) begin
                    word_q <= shreg_d;
                    rdy_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Framed byte-stream loader: 16-bit word count, payload, XOR checksum.
// Writes one packed word per 4 payload bytes and holds the CPU while loading.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    instr_mem_loader_if.slave  bus,
    output logic               cpu_hold_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    ld_state_e                state_q;
    logic                     in_ready_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic [MEM_CELL_SIZE-1:0] chk_q;
    logic [CNT_W-1:0]         n_q, wcnt_q, n_d;
    logic                     fire, launch, pk_vld, pk_last, pk_rdy;
    logic [WORD_LEN-1:0]      pk_word;

    assign fire   = bus.in_valid && in_ready_q;
    assign launch = start_i && (state_q inside {S_IDLE, S_DONE, S_ERR});
    assign pk_vld = fire && (state_q == S_DATA);
    assign n_d    = {n_q[CNT_W-1:MEM_CELL_SIZE], bus.in_data};

    loader_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (launch),
        .byte_vld_i   (pk_vld),
        .byte_i       (bus.in_data),
        .last_o       (pk_last),
        .word_ready_o (pk_rdy),
        .word_o       (pk_word)
    );

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = pk_rdy;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = pk_word;
    assign busy_o       = busy_q;
    assign cpu_hold_o   = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= '0;
            chk_q      <= '0;
            n_q        <= '0;
            wcnt_q     <= '0;
        end else begin
            // The last word's strobe happens in CHK, so the address stops at the final word.
            if (pk_rdy && state_q == S_DATA)
                wr_addr_q <= wr_addr_q + ADDR_W'(4);
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (start_i) begin
                    state_q    <= S_CNT_HI;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                    done_q     <= 1'b0;
                    err_q      <= 1'b0;
                    wr_addr_q  <= '0;
                    chk_q      <= '0;
                    wcnt_q     <= '0;
                end
                S_CNT_HI: if (fire) begin
                    n_q[CNT_W-1:MEM_CELL_SIZE] <= bus.in_data;
                    state_q                    <= S_CNT_LO;
                end
                S_CNT_LO: if (fire) begin
                    n_q <= n_d;
                    if (n_d > CNT_W'(MAX_WORDS)) begin
                        state_q    <= S_ERR;
                        err_q      <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (n_d == '0) begin
                        state_q <= S_CHK;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: if (fire) begin
                    chk_q <= chk_q ^ bus.in_data;
                    if (pk_last) begin
                        wcnt_q <= wcnt_q + CNT_W'(1);
                        if (wcnt_q + CNT_W'(1) == n_q)
                            state_q <= S_CHK;
                    end
                end
                S_CHK: if (fire) begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (bus.in_data == chk_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of framed loads plus reset/abort sequences.
module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, busy, done, err;

    instr_mem_loader_if bus();

    instr_mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .bus        (bus.slave),
        .cpu_hold_o (cpu_hold),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        bit          bad_chk;
        bit          rnd;
        bit          exp_done;
        bit          exp_err;
        int          exp_wr;
    } vec_t;

    vec_t vt [7];
    int n_vec = 0;
    int n_bad = 0;
    logic [ADDR_W-1:0] wa [$];
    logic [31:0]       wd [$];

    always @(negedge clk) if (bus.wr_en) begin
        wa.push_back(bus.wr_addr);
        wd.push_back(bus.wr_data);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // First 8 payload bytes are the reference frame; later ones a fixed pattern.
    function automatic logic [7:0] pbyte(input int i);
        logic [63:0] p;
        p = 64'h8020000A_04400800;
        if (i < 8) return p[63-8*i -: 8];
        return 8'((i * 37 + 11) & 255);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        logic r;
        if (rnd)
            for (int k = 0; k < 3 && $urandom_range(1, 0) == 1; k++) begin
                bus.in_valid = 1'b0;
                align();
            end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            r = bus.in_ready;
            align();
            if (r) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        align();
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        align();
        start        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("start_ready", bus.in_ready, 1);
        check("start_busy", {busy, cpu_hold}, 2'b11);
        check("start_clr", {done, err}, 2'b00);
        align();
    endtask

    task automatic run_load(input int v);
        vec_t c;
        logic [7:0] x, b;
        c = vt[v];
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(c.n[15:8], c.rnd);
        send_byte(c.n[7:0], c.rnd);
        if (c.n <= 16'(MAX_WORDS)) begin
            x = 8'h00;
            for (int i = 0; i < int'(c.n) * 4; i++) begin
                b = pbyte(i);
                x = x ^ b;
                send_byte(b, c.rnd);
            end
            send_byte(c.bad_chk ? (x ^ 8'h01) : x, c.rnd);
            bus.in_valid = 1'b0;
        end else begin
            bus.in_data = 8'h5A;
            repeat (3) @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check($sformatf("v%0d_done", v), done, c.exp_done);
        check($sformatf("v%0d_err", v), err, c.exp_err);
        check($sformatf("v%0d_idle", v), {busy, cpu_hold, bus.in_ready}, 3'b000);
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_nwr", v), wa.size(), c.exp_wr);
        for (int k = 0; k < wa.size() && k < c.exp_wr; k++) begin
            check($sformatf("v%0d_addr%0d", v, k), 32'(wa[k]), 32'(k * 4));
            check($sformatf("v%0d_data%0d", v, k), wd[k],
                  {pbyte(4*k), pbyte(4*k+1), pbyte(4*k+2), pbyte(4*k+3)});
        end
    endtask

    initial begin
        //         n       bad   rnd   done  err   writes
        vt[0] = '{16'd2,   1'b0, 1'b0, 1'b1, 1'b0, 2};
        vt[1] = '{16'd2,   1'b1, 1'b0, 1'b0, 1'b1, 2};
        vt[2] = '{16'd257, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vt[3] = '{16'd0,   1'b0, 1'b0, 1'b1, 1'b0, 0};
        vt[4] = '{16'd256, 1'b0, 1'b0, 1'b1, 1'b0, 256};
        vt[5] = '{16'd2,   1'b0, 1'b1, 1'b1, 1'b0, 2};
        vt[6] = '{16'd3,   1'b0, 1'b1, 1'b1, 1'b0, 3};

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {bus.in_ready, bus.wr_en, busy, cpu_hold, done, err}, 6'b0);
        check("rst_addr", 32'(bus.wr_addr), 0);
        check("rst_data", bus.wr_data, 0);
        align();
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_load(v);
            if (v == 0) begin
                check("ref_word0", wd.size() > 0 ? wd[0] : 32'hX, 32'h8020000A);
                check("ref_word1", wd.size() > 1 ? wd[1] : 32'hX, 32'h04400800);
            end
            if (v == 4)
                check("last_addr", wa.size() == 256 ? 32'(wa[255]) : 32'hX, 32'h3FC);
        end

        // Abort a load with reset after the 6th payload byte while the source keeps streaming.
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(pbyte(i), 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_ctl", {bus.in_ready, bus.wr_en, busy, cpu_hold, done, err}, 6'b0);
        check("abort_addr", 32'(bus.wr_addr), 0);
        check("abort_data", bus.wr_data, 0);
        align();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_ready", bus.in_ready, 0);
        check("abort_nwr", wa.size(), 1);
        check("abort_word", wd.size() > 0 ? wd[0] : 32'hX, 32'h8020000A);
        bus.in_valid = 1'b0;
        run_load(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
